// File: rtl/bar_array_to_position_pkg.sv
// rtl/bar_array_to_position_pkg.sv - shared level-meter types and helpers
//
// Bar-array format shared by generator and decoder:
//   bit k of the array is set iff (k <= position) or (k == peak).
//   Bit 0 is the lowest segment. When no peak dot is present, peak == position.
package bar_array_to_position_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_OUT  = 2'd2
    } meter_state_t;

    // Width of a position/peak field for a bar of w segments (never below one bit).
    function automatic int calc_width_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bar_array_to_position.sv
// rtl/bar_array_to_position.sv - serial bar-array decoder recovering level and peak-hold positions
module bar_array_to_position
    import bar_array_to_position_pkg::*;
#(
    parameter int width = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_valid,
    output logic                                   i_ready,
    input  logic [width-1:0]                       i_array,
    output logic                                   o_valid,
    input  logic                                   o_ready,
    output logic [calc_width_bits(width)-1:0]      o_position,
    output logic [calc_width_bits(width)-1:0]      o_peak,
    output logic                                   o_error
);

    localparam int width_bits = calc_width_bits(width);
    localparam logic [width_bits-1:0] last_index = width_bits'(width - 1);

    meter_state_t            state, state_n;
    logic [width_bits-1:0]   count, count_n;
    logic [width-1:0]        shreg, shreg_n;
    logic                    in_run, in_run_n;
    logic                    dot_seen, dot_seen_n;
    logic                    err, err_n;
    logic [width_bits-1:0]   pos, pos_n;
    logic [width_bits-1:0]   peak, peak_n;
    logic                    i_ready_n;
    logic                    o_valid_n;
    logic [width_bits-1:0]   o_position_n;
    logic [width_bits-1:0]   o_peak_n;
    logic                    o_error_n;
    logic                    scan_bit;

    // Segments are consumed LSB first, so the current bit is always the bottom of the shifter.
    assign scan_bit = shreg[0];

    // State and datapath registers; async reset discards any in-flight scan or result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            shreg      <= '0;
            in_run     <= 1'b0;
            dot_seen   <= 1'b0;
            err        <= 1'b0;
            pos        <= '0;
            peak       <= '0;
            i_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_position <= '0;
            o_peak     <= '0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            shreg      <= shreg_n;
            in_run     <= in_run_n;
            dot_seen   <= dot_seen_n;
            err        <= err_n;
            pos        <= pos_n;
            peak       <= peak_n;
            i_ready    <= i_ready_n;
            o_valid    <= o_valid_n;
            o_position <= o_position_n;
            o_peak     <= o_peak_n;
            o_error    <= o_error_n;
        end
    end

    // Next-state: accept in IDLE, classify one segment per cycle in SCAN, hold result in OUT.
    always_comb begin
        state_n      = state;
        count_n      = count;
        shreg_n      = shreg;
        in_run_n     = in_run;
        dot_seen_n   = dot_seen;
        err_n        = err;
        pos_n        = pos;
        peak_n       = peak;
        i_ready_n    = i_ready;
        o_valid_n    = o_valid;
        o_position_n = o_position;
        o_peak_n     = o_peak;
        o_error_n    = o_error;

        case (state)
            ST_IDLE: begin
                if (i_valid && i_ready) begin
                    shreg_n    = i_array;
                    in_run_n   = 1'b1;
                    dot_seen_n = 1'b0;
                    err_n      = 1'b0;
                    pos_n      = '0;
                    peak_n     = '0;
                    count_n    = '0;
                    i_ready_n  = 1'b0;
                    state_n    = ST_SCAN;
                end
            end

            ST_SCAN: begin
                shreg_n = shreg >> 1;
                if (count == '0 && !scan_bit) begin
                    // Bar must start at segment 0; an empty bottom segment is malformed.
                    err_n    = 1'b1;
                    in_run_n = 1'b0;
                end else if (in_run && scan_bit) begin
                    pos_n  = count;
                    peak_n = count;
                end else if (in_run) begin
                    in_run_n = 1'b0;
                end else if (scan_bit && !dot_seen) begin
                    dot_seen_n = 1'b1;
                    peak_n     = count;
                end else if (scan_bit) begin
                    // A second set bit above the run: two dots or a dot wider than one segment.
                    err_n = 1'b1;
                end

                if (count == last_index) begin
                    count_n      = '0;
                    o_valid_n    = 1'b1;
                    o_error_n    = err_n;
                    o_position_n = err_n ? '0 : pos_n;
                    o_peak_n     = err_n ? '0 : peak_n;
                    state_n      = ST_OUT;
                end else begin
                    count_n = count + 1'b1;
                end
            end

            ST_OUT: begin
                if (o_ready) begin
                    o_valid_n = 1'b0;
                    i_ready_n = 1'b1;
                    state_n   = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bar_array_to_position.sv
// tb/tb_bar_array_to_position.sv - self-checking bench for bar_array_to_position
module tb_bar_array_to_position;

    localparam int W  = 8;
    localparam int WB = 3;

    logic          clk;
    logic          reset;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  i_array;
    logic          o_valid;
    logic          o_ready;
    logic [WB-1:0] o_position;
    logic [WB-1:0] o_peak;
    logic          o_error;

    int checks = 0;
    int errors = 0;

    bar_array_to_position #(.width(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_array    (i_array),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_position (o_position),
        .o_peak     (o_peak),
        .o_error    (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search every (position, peak) pair for one whose bar image equals the array.
    // Highest position wins so a dot touching the run is read as a longer run.
    function automatic void ref_decode(input logic [W-1:0] arr, output int rpos, output int rpk, output logic rerr);
        logic [W-1:0] img;
        logic found;
        found = 1'b0;
        rpos = 0; rpk = 0;
        for (int p = W - 1; p >= 0; p--) begin
            for (int k = p; k < W; k++) begin
                img = '0;
                for (int b = 0; b < W; b++) if (b <= p || b == k) img[b] = 1'b1;
                if (!found && img == arr) begin
                    found = 1'b1; rpos = p; rpk = k;
                end
            end
        end
        rerr = !found;
        if (!found) begin rpos = 0; rpk = 0; end
    endfunction

    // Drive one array, wait for the result, optionally acknowledge it. Returns observations only.
    task automatic decode(input logic [W-1:0] arr, input logic ack,
                          output int lat, output logic [WB-1:0] pos, output logic [WB-1:0] pk,
                          output logic er, output logic busy_ok);
        int n;
        logic done;
        busy_ok = 1'b1;
        lat = -1;
        @(negedge clk);
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        i_valid = 1'b1;
        i_array = arr;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_array = W'($urandom);
        done = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!done) begin
                @(posedge clk);
                #1;
                if (o_valid) begin
                    lat = k;
                    done = 1'b1;
                end else if (i_ready) begin
                    busy_ok = 1'b0;
                end
                if (i_ready && o_valid) busy_ok = 1'b0;
            end
        end
        pos = o_position;
        pk  = o_peak;
        er  = o_error;
        if (ack) begin
            @(negedge clk);
            o_ready = 1'b1;
            @(posedge clk);
            #1;
            o_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({i_ready, o_valid, o_position, o_peak, o_error} !== {1'b1, 1'b0, 3'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b pos=%0d pk=%0d err=%b exp rdy=1 vld=0 pos=0 pk=0 err=0",
                     i_ready, o_valid, o_position, o_peak, o_error);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] t_arr [10] = '{8'b0000_1111, 8'b0100_0011, 8'hFF, 8'h01, 8'b1000_0001,
                                    8'h00, 8'b0101_0001, 8'b0110_0001, 8'b1111_1110, 8'b0000_0111};
        int t_pos [10] = '{3, 1, 7, 0, 0, 0, 0, 0, 0, 2};
        int t_pk  [10] = '{3, 6, 7, 0, 7, 0, 0, 0, 0, 2};
        logic t_err [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat;
        logic [WB-1:0] pos, pk;
        logic er, busy_ok;
        for (int i = 0; i < 10; i++) begin
            decode(t_arr[i], 1'b1, lat, pos, pk, er, busy_ok);
            checks++;
            if (int'(pos) !== t_pos[i] || int'(pk) !== t_pk[i] || er !== t_err[i]) begin
                errors++;
                $display("FAIL directed_%0d arr=%b got pos=%0d pk=%0d err=%b exp pos=%0d pk=%0d err=%b",
                         i, t_arr[i], pos, pk, er, t_pos[i], t_pk[i], t_err[i]);
            end
            checks++;
            if (lat !== W || busy_ok !== 1'b1) begin
                errors++;
                $display("FAIL directed_timing_%0d got latency=%0d busy_ok=%b exp latency=%0d busy_ok=1",
                         i, lat, busy_ok, W);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] arr;
        int p, k, rpos, rpk, lat;
        logic rerr, er, busy_ok;
        logic [WB-1:0] pos, pk;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) begin
                p = $urandom_range(W - 1, 0);
                k = $urandom_range(W - 1, p);
                arr = '0;
                for (int b = 0; b < W; b++) if (b <= p || b == k) arr[b] = 1'b1;
            end else begin
                arr = W'($urandom);
            end
            ref_decode(arr, rpos, rpk, rerr);
            decode(arr, 1'b1, lat, pos, pk, er, busy_ok);
            checks++;
            if (int'(pos) !== rpos || int'(pk) !== rpk || er !== rerr || lat !== W) begin
                errors++;
                $display("FAIL random_%0d arr=%b got pos=%0d pk=%0d err=%b lat=%0d exp pos=%0d pk=%0d err=%b lat=%0d",
                         i, arr, pos, pk, er, lat, rpos, rpk, rerr, W);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [WB-1:0] pos, pk;
        logic er, busy_ok, stable;
        decode(8'b0010_0011, 1'b0, lat, pos, pk, er, busy_ok);
        checks++;
        if (int'(pos) !== 1 || int'(pk) !== 5 || er !== 1'b0 || lat !== W) begin
            errors++;
            $display("FAIL bp_result got pos=%0d pk=%0d err=%b lat=%0d exp pos=1 pk=5 err=0 lat=%0d",
                     pos, pk, er, lat, W);
        end
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_valid = 1'($urandom);
            i_array = W'($urandom);
            @(posedge clk);
            #1;
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_position !== 3'd1 || o_peak !== 3'd5 || o_error !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got vld=%b rdy=%b pos=%0d pk=%0d err=%b exp vld=1 rdy=0 pos=1 pk=5 err=0",
                     o_valid, i_ready, o_position, o_peak, o_error);
        end
        @(negedge clk);
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_position !== 3'd1 || o_peak !== 3'd5) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b pos=%0d pk=%0d exp vld=0 rdy=1 pos=1 pk=5",
                     o_valid, i_ready, o_position, o_peak);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept got vld=%b rdy=%b exp vld=0 rdy=1", o_valid, i_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        logic [WB-1:0] pos, pk;
        logic er, busy_ok;
        @(negedge clk);
        i_valid = 1'b1;
        i_array = 8'b0001_1111;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0 || o_position !== 3'd0 || o_peak !== 3'd0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan got rdy=%b vld=%b pos=%0d pk=%0d err=%b exp rdy=1 vld=0 pos=0 pk=0 err=0",
                     i_ready, o_valid, o_position, o_peak, o_error);
        end
        @(negedge clk);
        reset = 1'b0;
        decode(8'b0010_0111, 1'b1, lat, pos, pk, er, busy_ok);
        checks++;
        if (int'(pos) !== 2 || int'(pk) !== 5 || er !== 1'b0 || lat !== W) begin
            errors++;
            $display("FAIL after_reset got pos=%0d pk=%0d err=%b lat=%0d exp pos=2 pk=5 err=0 lat=%0d",
                     pos, pk, er, lat, W);
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_array = '0;
        o_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
